// File: rtl/fpga_robots_game_tm_cell_if.sv
// Bundle between game logic and the tile-map cell engine.
// Carries the command/response handshake and the video generator tile-map port.
// Ports (slave = cell engine):
//   cmd_valid/cmd_ready/cmd_op/cmd_x/cmd_y/cmd_data : command handshake
//   rsp_valid/rsp_err/rsp_cell/rsp_work            : completion pulse + data
//   tm_adr/tm_red/tm_wrt/tm_wen                     : tile-map memory port
interface fpga_robots_game_tm_cell_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [6:0] cmd_x;
    logic [6:0] cmd_y;
    logic [3:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_err;
    logic [1:0] rsp_cell;
    logic [3:0] rsp_work;
    logic [12:0] tm_adr;
    logic [7:0] tm_red;
    logic [7:0] tm_wrt;
    logic       tm_wen;

    modport slave (
        input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data, tm_red,
        output cmd_ready, rsp_valid, rsp_err, rsp_cell, rsp_work,
        output tm_adr, tm_wrt, tm_wen
    );

    modport master (
        output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_data, tm_red,
        input  cmd_ready, rsp_valid, rsp_err, rsp_cell, rsp_work,
        input  tm_adr, tm_wrt, tm_wen
    );
endinterface

// File: rtl/fpga_robots_game_tm_cell.sv
// Tile-map cell access engine: per-cell read / read-modify-write and bulk clear.
// Ports: clk, rst (sync, active-high); s_bus (slave modport) carries the
// command/response handshake and the tile-map port (tm_adr/tm_red/tm_wrt/tm_wen).
module fpga_robots_game_tm_cell #(
    parameter int         PA_COLS = 120,
    parameter int         PA_ROWS = 96,
    parameter logic [7:0] CLR_VAL = 8'h00
) (
    input  logic clk,
    input  logic rst,
    fpga_robots_game_tm_cell_if.slave s_bus
);

    localparam logic [6:0] LP_COLS     = 7'(PA_COLS);
    localparam logic [6:0] LP_ROWS     = 7'(PA_ROWS);
    localparam logic [6:0] LP_LAST_COL = 7'(PA_COLS - 1);
    localparam logic [5:0] LP_LAST_ROW = 6'(PA_ROWS / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MRG,
        S_WR,
        S_CLR
    } state_e;

    typedef enum logic [1:0] {
        OP_READ,
        OP_WR_CELL,
        OP_WR_WORK,
        OP_CLEAR
    } op_e;

    state_e      r_state, w_state;
    op_e         r_op, w_op;
    logic        r_ysel, w_ysel;
    logic [3:0]  r_data, w_data;
    logic        r_ready, w_ready;
    logic        r_rsp_valid, w_rsp_valid;
    logic        r_rsp_err, w_rsp_err;
    logic [1:0]  r_rsp_cell, w_rsp_cell;
    logic [3:0]  r_rsp_work, w_rsp_work;
    logic [12:0] r_adr, w_adr;
    logic [7:0]  r_wrt, w_wrt;
    logic        r_wen, w_wen;

    logic        w_accept;
    logic        w_oor;
    logic [1:0]  w_red_cell;
    logic [7:0]  w_cell_merge;
    logic [5:0]  w_clr_row;
    logic [6:0]  w_clr_col;
    logic        w_clr_last;

    assign w_accept = r_ready && s_bus.cmd_valid;
    assign w_oor    = (s_bus.cmd_x >= LP_COLS) || (s_bus.cmd_y >= LP_ROWS);

    // Odd rows live in bits [3:2], even rows in [1:0] of the shared byte.
    assign w_red_cell = r_ysel ? s_bus.tm_red[3:2] : s_bus.tm_red[1:0];
    assign w_cell_merge = r_ysel
        ? {s_bus.tm_red[7:4], r_data[1:0], s_bus.tm_red[1:0]}
        : {s_bus.tm_red[7:2], r_data[1:0]};

    // The clear sweep walks tm_adr itself; no separate counters needed.
    assign w_clr_row  = r_adr[12:7];
    assign w_clr_col  = r_adr[6:0];
    assign w_clr_last = (w_clr_row == LP_LAST_ROW) && (w_clr_col == LP_LAST_COL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_READ;
            r_ysel      <= 1'b0;
            r_data      <= 4'h0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_cell  <= 2'd0;
            r_rsp_work  <= 4'h0;
            r_adr       <= 13'd0;
            r_wrt       <= 8'h00;
            r_wen       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_op        <= w_op;
            r_ysel      <= w_ysel;
            r_data      <= w_data;
            r_ready     <= w_ready;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_err   <= w_rsp_err;
            r_rsp_cell  <= w_rsp_cell;
            r_rsp_work  <= w_rsp_work;
            r_adr       <= w_adr;
            r_wrt       <= w_wrt;
            r_wen       <= w_wen;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_op        = r_op;
        w_ysel      = r_ysel;
        w_data      = r_data;
        w_ready     = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_err   = r_rsp_err;
        w_rsp_cell  = r_rsp_cell;
        w_rsp_work  = r_rsp_work;
        w_adr       = r_adr;
        w_wrt       = r_wrt;
        w_wen       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (w_accept) begin
                    w_ready = 1'b0;
                    w_op    = op_e'(s_bus.cmd_op);
                    w_ysel  = s_bus.cmd_y[0];
                    w_data  = s_bus.cmd_data;
                    if (op_e'(s_bus.cmd_op) == OP_CLEAR) begin
                        // First sweep write goes out with the state change.
                        w_state = S_CLR;
                        w_adr   = 13'd0;
                        w_wrt   = CLR_VAL;
                        w_wen   = 1'b1;
                    end else if (w_oor) begin
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                        w_rsp_cell  = 2'd0;
                        w_rsp_work  = 4'h0;
                        w_ready     = 1'b1;
                    end else begin
                        w_adr   = {s_bus.cmd_y[6:1], s_bus.cmd_x};
                        w_state = S_RD;
                    end
                end
            end
            S_RD: begin
                w_state = S_MRG;
            end
            S_MRG: begin
                w_rsp_cell = w_red_cell;
                w_rsp_work = s_bus.tm_red[7:4];
                w_rsp_err  = 1'b0;
                unique case (r_op)
                    OP_WR_CELL: begin
                        w_wrt   = w_cell_merge;
                        w_wen   = 1'b1;
                        w_state = S_WR;
                    end
                    OP_WR_WORK: begin
                        w_wrt   = {r_data, s_bus.tm_red[3:0]};
                        w_wen   = 1'b1;
                        w_state = S_WR;
                    end
                    default: begin
                        w_rsp_valid = 1'b1;
                        w_ready     = 1'b1;
                        w_state     = S_IDLE;
                    end
                endcase
            end
            S_WR: begin
                w_rsp_valid = 1'b1;
                w_ready     = 1'b1;
                w_state     = S_IDLE;
            end
            S_CLR: begin
                if (w_clr_last) begin
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b0;
                    w_ready     = 1'b1;
                    w_state     = S_IDLE;
                end else begin
                    w_wen = 1'b1;
                    if (w_clr_col == LP_LAST_COL) begin
                        w_adr = {w_clr_row + 6'd1, 7'd0};
                    end else begin
                        w_adr = {w_clr_row, w_clr_col + 7'd1};
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign s_bus.cmd_ready = r_ready;
    assign s_bus.rsp_valid = r_rsp_valid;
    assign s_bus.rsp_err   = r_rsp_err;
    assign s_bus.rsp_cell  = r_rsp_cell;
    assign s_bus.rsp_work  = r_rsp_work;
    assign s_bus.tm_adr    = r_adr;
    assign s_bus.tm_wrt    = r_wrt;
    assign s_bus.tm_wen    = r_wen;

endmodule
